// File: rtl/muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : muldiv_pkg                                                   |
// | Purpose  : Shared types for the iterative multiply/divide unit          |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package muldiv_pkg;

  // RV32M funct3 encodings, shared with the instruction decoder
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : muldiv_if                                                    |
// | Purpose  : start/busy/done request bus for the multiply/divide unit     |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
interface muldiv_if #(
  parameter int DATA_WIDTH = 32
) ();
  import muldiv_pkg::*;

  logic                  start;
  muldiv_op_t            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  // Requester side (execute stage)
  modport master (
    output start, op, a, b,
    input  busy, done, result
  );

  // Unit side
  modport slave (
    input  start, op, a, b,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : muldiv_unit                                                  |
// | Purpose  : Iterative RV32M multiply/divide, one bit per cycle, with     |
// |            magnitude datapath and a final sign-correction stage         |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  muldiv_if.slave   bus
);
  localparam int                    CW      = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]         C_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] C_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  muldiv_state_t             r_state, w_next;
  muldiv_op_t                r_op;
  logic [CW-1:0]             r_cnt;
  logic [2*DATA_WIDTH-1:0]   r_acc;    // hi: partial product; lo: multiplier or dividend/quotient
  logic [DATA_WIDTH:0]       r_rem;    // restoring-division partial remainder
  logic [DATA_WIDTH-1:0]     r_opnd;   // multiplicand or divisor magnitude
  logic                      r_neg;    // negate the selected result in FIX
  logic                      r_done;
  logic [DATA_WIDTH-1:0]     r_result;

  logic                      w_a_sgn, w_b_sgn, w_is_div, w_dz, w_ovf, w_special, w_neg;
  logic [DATA_WIDTH-1:0]     w_mag_a, w_mag_b;
  logic [DATA_WIDTH:0]       w_sum;
  logic [DATA_WIDTH+1:0]     w_shift, w_diff;
  logic [2*DATA_WIDTH-1:0]   w_prod;
  logic [DATA_WIDTH-1:0]     w_quo, w_rmd, w_fix;

  // Operand decode at accept: signedness, magnitudes and the two divide special cases
  always_comb begin
    w_a_sgn   = (bus.op == OP_MULH || bus.op == OP_MULHSU || bus.op == OP_DIV || bus.op == OP_REM)
                && bus.a[DATA_WIDTH-1];
    w_b_sgn   = (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM) && bus.b[DATA_WIDTH-1];
    w_mag_a   = w_a_sgn ? -bus.a : bus.a;
    w_mag_b   = w_b_sgn ? -bus.b : bus.b;
    w_is_div  = bus.op[2];
    w_dz      = w_is_div && (bus.b == '0);
    w_ovf     = (bus.op == OP_DIV || bus.op == OP_REM) && (bus.a == C_MIN) && (bus.b == '1);
    w_special = w_dz || w_ovf;
    // remainder follows the dividend; products and quotients follow the sign XOR
    w_neg     = (bus.op == OP_REM || bus.op == OP_REMU) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
  end

  // One iteration step: shift-add for multiply, trial subtraction for divide
  always_comb begin
    w_sum   = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_shift = {r_rem, r_acc[DATA_WIDTH-1]};
    w_diff  = w_shift - {2'b00, r_opnd};
  end

  // Sign correction and result selection for the FIX cycle
  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_neg ? -r_acc[DATA_WIDTH-1:0] : r_acc[DATA_WIDTH-1:0];
    w_rmd  = r_neg ? -r_rem[DATA_WIDTH-1:0] : r_rem[DATA_WIDTH-1:0];
    case (r_op)
      OP_MUL:                        w_fix = w_prod[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fix = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:               w_fix = w_quo;
      default:                       w_fix = w_rmd;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; special cases bypass the iteration entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = w_special ? ST_FIX : ST_CALC;
      ST_CALC: if (r_cnt == C_LAST) w_next = ST_FIX;
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in CALC, publish in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_opnd   <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op  <= bus.op;
            r_cnt <= '0;
            if (w_special) begin
              r_opnd <= '0;
              r_neg  <= 1'b0;
              r_acc  <= {{DATA_WIDTH{1'b0}}, (w_dz ? {DATA_WIDTH{1'b1}} : C_MIN)};
              r_rem  <= w_dz ? {1'b0, bus.a} : '0;
            end else begin
              r_opnd <= w_is_div ? w_mag_b : w_mag_a;
              r_neg  <= w_neg;
              r_acc  <= {{DATA_WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
              r_rem  <= '0;
            end
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_op[2]) begin
            if (!w_diff[DATA_WIDTH+1]) begin
              r_rem <= w_diff[DATA_WIDTH:0];
              r_acc <= {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[DATA_WIDTH:0];
              r_acc <= {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc <= {w_sum, r_acc[DATA_WIDTH-1:1]};
          end
        end
        ST_FIX: begin
          r_result <= w_fix;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule
`default_nettype wire
